mole_generator: RTL
===================

# mole_generator

Upstream stage of the mole-match comparator: picks the lit mole position each round, holds it for a bounded "up" window, and closes the round on the comparator's hit result or on timeout. The `mole` output drives the comparator's random-position input. Its `hit` result comes back to this block to end the round. A 16-bit LFSR supplies positions. A round counter ends the game after a fixed number of rounds.

## Interface
- `UP_CYCLES`, default 50_000_000: cycles a mole stays lit before a miss.
- `GAP_CYCLES`, default 12_500_000: dark cycles between moles.
- `ROUNDS`, default 20: rounds per game (1..255).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; a zero seed is replaced by 16'hACE1.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a game from IDLE or DONE.
- `hit`  in  1  comparator result (switches equal `mole`); level.
- `mole`  out  5  one-hot lit position; 0 when dark.
- `mole_valid`  out  1  high while `mole` is lit.
- `hit_pulse`  out  1  one cycle; round ended by hit.
- `miss_pulse`  out  1  one cycle; round ended by timeout.
- `round_cnt`  out  8  rounds completed in the current game.
- `game_over`  out  1  high in DONE.

## Operation
- States: IDLE, GAP, SHOW, DONE.
- IDLE / DONE → GAP on `start`. The `start` transition clears `round_cnt` and `game_over`. `start` is ignored in GAP and SHOW.
- GAP:
  - Load the timer with GAP_CYCLES−1 on entry and count down.
  - At 0, latch a new position and go to SHOW.
- SHOW:
  - Load the timer with UP_CYCLES−1 and count down.
  - `hit`=1 → assert `hit_pulse`, clear `mole`, `round_cnt`+1.
  - Otherwise, timer at 0 → assert `miss_pulse`, clear `mole`, `round_cnt`+1.
  - After either event: go to DONE if the new `round_cnt`==ROUNDS, else to GAP.
- `hit` is sampled only in SHOW. Outside SHOW it is ignored, which masks the comparator's all-off match while `mole`=0.
- Position choice:
  - Take idx = lfsr[2:0]; if idx>4, set idx = idx−3.
  - If idx equals the previous round's idx, set idx = (idx+1) mod 5.
  - `mole` = 1<<idx.
  - Previous idx resets to 0.
- LFSR:
  - Fibonacci, taps 16,14,13,11; advances every clock after reset.
  - The seed is never zero, so the LFSR never locks up.
- Timer:
  - Down-counter of width $clog2(max(UP_CYCLES,GAP_CYCLES)).
  - No wrap: reload happens on the state transition.
- `round_cnt` saturates at ROUNDS and holds in DONE.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE, LFSR = seed;
  - `mole`=0, `mole_valid`=0, `hit_pulse`=0, `miss_pulse`=0, `round_cnt`=0, `game_over`=0.
- `start` at cycle t → GAP from t+1. `mole_valid` rises at t+1+GAP_CYCLES.
- SHOW lasts at most UP_CYCLES cycles. A `hit` sampled at edge e gives `hit_pulse` high, `mole`=0 and `mole_valid`=0 all from e+1, for one cycle.
- Same-cycle `hit` and timeout: the hit wins. Only `hit_pulse` fires.
- `mole` and `mole_valid` are registered and change together. The comparator sees a new position the same cycle `mole_valid` rises.
- Reset mid-round drops all outputs immediately. No pulse is emitted.

## Structure
- Package `mole_pkg` holds:
  - state enum;
  - NUM_MOLES = 5;
  - LFSR taps and default seed;
  - the idx-folding function.
- Sub-module `lfsr16` (`clk`, `reset_n`, seed parameter, 16-bit `q`) is natural and reusable by other random consumers.

## Test plan
All scenarios use UP_CYCLES=8, GAP_CYCLES=4, ROUNDS=3 unless stated.
- Reset, then `start` at cycle 10 → `mole_valid` rises at cycle 15; `mole` is one-hot and nonzero; `round_cnt`=0.
- `hit` on the 3rd SHOW cycle → `hit_pulse` for one cycle, `mole`=0 the next cycle, `round_cnt`=1; next `mole_valid` 4 cycles later.
- `hit` held low → `miss_pulse` exactly 8 cycles after `mole_valid` rose; `hit_pulse` stays 0.
- `hit` rises on the final SHOW cycle → `hit_pulse`=1, `miss_pulse`=0.
- Three rounds → `game_over`=1 with `round_cnt`=3, and `start` is ignored mid-game. A later `start` clears `round_cnt` to 0 and `game_over` to 0, and the next mole appears after 4 gap cycles.
- `reset_n` low mid-SHOW → all outputs 0 without waiting for a clock edge. Separately, with ROUNDS=255 over 255 rounds: no two consecutive moles are equal, and every idx 0..4 appears.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole generator: FSM states, LFSR constants
// and the position-folding logic that maps LFSR bits onto the five moles.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          NUM_MOLES         = 5;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [2:0] fold_idx(input logic [2:0] raw);
        logic [2:0] f;
        if (raw > 3'd4) begin
            f = raw - 3'd3;
        end else begin
            f = raw;
        end
        return f;
    endfunction

    // Bumps the folded index so the same mole never lights twice in a row
    function automatic logic [2:0] next_idx(input logic [2:0] raw, input logic [2:0] prev);
        logic [2:0] f;
        logic [2:0] n;
        f = fold_idx(raw);
        if (f == prev) begin
            if (f == 3'(NUM_MOLES - 1)) begin
                n = 3'd0;
            end else begin
                n = f + 3'd1;
            end
        end else begin
            n = f;
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is swapped for the default
// so the register can never lock up in the all-zero state.
module lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic fb_s;

    // Feedback bit is the XOR of the tapped stages
    always_comb begin
        fb_s = ^(q & LFSR_TAPS);
    end

    // Shift register, advancing every clock once out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED_EFF;
        end else begin
            q <= {q[14:0], fb_s};
        end
    end

endmodule

// File: rtl/mole_generator.sv
// Round sequencer for the mole-match game: dark gap, lit mole, then close the
// round on a comparator hit or a timeout, ending the game after ROUNDS rounds.
module mole_generator
    import mole_pkg::*;
#(
    parameter int          UP_CYCLES  = 50_000_000,
    parameter int          GAP_CYCLES = 12_500_000,
    parameter int          ROUNDS     = 20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hit,
    output logic [4:0] mole,
    output logic       mole_valid,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] round_cnt,
    output logic       game_over
);

    localparam int TMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] UP_LOAD  = TW'(UP_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_ZERO   = TW'(0);
    localparam logic [7:0]    ROUNDS_C = 8'(ROUNDS);

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      prev_idx_r;
    logic [15:0]     lfsr_s;
    logic [2:0]      idx_s;
    logic [7:0]      next_cnt_s;
    logic            last_s;
    logic            timer_zero_s;
    logic            unused_lfsr_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_s)
    );

    // Only the low three LFSR bits choose the position
    assign unused_lfsr_s = ^lfsr_s[15:3];

    // Next position, round count and end-of-game detection
    always_comb begin
        idx_s        = next_idx(lfsr_s[2:0], prev_idx_r);
        next_cnt_s   = round_cnt + 8'd1;
        last_s       = (next_cnt_s == ROUNDS_C);
        timer_zero_s = (timer_r == T_ZERO);
    end

    // Game FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= T_ZERO;
            prev_idx_r <= 3'd0;
            mole       <= 5'd0;
            mole_valid <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            round_cnt  <= 8'd0;
            game_over  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r   <= ST_GAP;
                        timer_r   <= GAP_LOAD;
                        round_cnt <= 8'd0;
                        game_over <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (timer_zero_s) begin
                        state_r    <= ST_SHOW;
                        timer_r    <= UP_LOAD;
                        mole       <= 5'b00001 << idx_s;
                        mole_valid <= 1'b1;
                        prev_idx_r <= idx_s;
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                ST_SHOW: begin
                    // A hit on the final lit cycle still counts as a hit
                    if (hit || timer_zero_s) begin
                        hit_pulse  <= hit;
                        miss_pulse <= ~hit;
                        mole       <= 5'd0;
                        mole_valid <= 1'b0;
                        round_cnt  <= next_cnt_s;
                        if (last_s) begin
                            state_r   <= ST_DONE;
                            game_over <= 1'b1;
                        end else begin
                            state_r <= ST_GAP;
                            timer_r <= GAP_LOAD;
                        end
                    end else begin
                        timer_r <= timer_r - T_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
